uart_rx: RTL and testbench

Oversampling UART receiver: recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from a serial line and presents each byte with a one-cycle valid strobe. It is the receive-side counterpart of the UART transmitter and consumes the line that transmitter produces, either from an external pin or in loopback. It runs on a clock at OVERSAMPLE × baud rate and samples each bit at its midpoint.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver.
// Samples each bit at its midpoint and strobes valid/frame_err for one cycle.
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_baud,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      sh_q, sh_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;

   logic            rxs;
   logic            at_mid;
   logic            at_last;
   logic [CW-1:0]   cnt_inc;

   assign sync1_d = rx;
   assign sync2_d = sync1_q;
   assign rxs     = sync2_q;

   assign at_mid  = (cnt_q == MID);
   assign at_last = (cnt_q == LAST);
   assign cnt_inc = at_last ? '0 : cnt_q + 1'b1;

   // State, counters, datapath and synchronizer registers.
   always_ff @(posedge clk_baud or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         rx_byte_q <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         rx_byte_q <= rx_byte_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
      end
   end

   // Next-state: walk start, data and stop bits; park in WAIT on a low stop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            if (at_mid) state_d = rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (at_last && idx_q == 3'd7) state_d = S_STOP;
         end
         S_STOP: begin
            if (at_last) state_d = rxs ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output pulses for the current state.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sh_d      = sh_q;
      rx_byte_d = rx_byte_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
         end
         S_START: begin
            cnt_d = at_mid ? '0 : cnt_inc;
            idx_d = '0;
         end
         S_DATA: begin
            cnt_d = cnt_inc;
            if (at_last) begin
               sh_d  = {rxs, sh_q[7:1]};
               idx_d = idx_q + 3'd1;
            end
         end
         S_STOP: begin
            cnt_d = cnt_inc;
            if (at_last) begin
               if (rxs) begin
                  rx_byte_d = sh_q;
                  valid_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            cnt_d = '0;
         end
         default: begin
            cnt_d = '0;
            idx_d = '0;
         end
      endcase
   end

   assign rx_byte   = rx_byte_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table, hand-written and random frames for uart_rx.
// Expected pulses and timing come from the frame timeline, not the RTL.
module tb_uart_rx;

   localparam int OS = 16;
   localparam int LAT = 3 + OS / 2 + 9 * OS;

   logic       clk_baud = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] rx_byte;
   logic       valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk_baud  (clk_baud),
      .rst       (rst),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk_baud = ~clk_baud;

   int cyc = 0;
   always @(posedge clk_baud) cyc <= cyc + 1;

   int n_vec = 0;
   int n_miss = 0;

   typedef struct {
      int         t;
      bit         ferr;
      logic [7:0] b;
   } ev_t;

   ev_t evq[$];
   ev_t expq[$];

   int n_both = 0;
   int n_long = 0;
   int n_bytechg = 0;
   int n_busy_rise = 0;
   int busy_rise_t = -1;
   int busy_fall_t = -1;
   logic pv = 1'b0;
   logic pf = 1'b0;
   logic pb = 1'b0;
   logic [7:0] pbyte = 8'h00;

   // Record every pulse and busy edge, and flag protocol violations.
   always @(negedge clk_baud) begin
      if (!rst) begin
         if (valid || frame_err) evq.push_back('{cyc, frame_err, rx_byte});
         if (valid && frame_err) n_both <= n_both + 1;
         if ((valid && pv) || (frame_err && pf)) n_long <= n_long + 1;
         if (rx_byte !== pbyte && !valid) n_bytechg <= n_bytechg + 1;
         if (busy && !pb) begin
            busy_rise_t <= cyc;
            n_busy_rise <= n_busy_rise + 1;
         end
         if (!busy && pb) busy_fall_t <= cyc;
      end
      pv    <= valid;
      pf    <= frame_err;
      pb    <= busy;
      pbyte <= rx_byte;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_baud);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic hold(input logic v);
      rx = v;
      repeat (OS) tick();
   endtask

   // Caller must be aligned just after a rising edge.
   task automatic send_frame(input logic [7:0] d, input bit stop,
                             output int fall);
      fall = cyc;
      hold(1'b0);
      for (int k = 0; k < 8; k++) hold(d[k]);
      hold(stop);
   endtask

   task automatic expect_ev(input string name, input int t, input bit ferr,
                            input logic [7:0] b, output int tobs);
      ev_t ev;
      tobs = -1;
      while (evq.size() == 0 && cyc < t + 40) @(negedge clk_baud);
      if (evq.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: no pulse seen, expected one at cycle %0d",
                  name, t);
      end else begin
         ev = evq.pop_front();
         tobs = ev.t;
         check({name, " time"}, ev.t, t);
         check({name, " kind"}, 32'(ev.ferr), 32'(ferr));
         check({name, " byte"}, 32'(ev.b), 32'(b));
      end
   endtask

   typedef struct {
      logic [7:0] d;
      bit         stop;
      bit         ferr;
      logic [7:0] eb;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end

   initial begin
      int f, f2, t1, t2, bad, nr, lo;
      logic [7:0] d;
      logic [7:0] last_good;
      bit stop;

      tbl[0] = '{8'h3C, 1'b0, 1'b1, 8'hA5};
      tbl[1] = '{8'h00, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
      tbl[3] = '{8'h5A, 1'b0, 1'b1, 8'hFF};
      tbl[4] = '{8'h81, 1'b1, 1'b0, 8'h81};
      tbl[5] = '{8'h7E, 1'b1, 1'b0, 8'h7E};

      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) tick();
      check("reset rx_byte", 32'(rx_byte), 32'h00);
      check("reset valid", 32'(valid), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      bad = 0;
      repeat (100) begin
         tick();
         if (valid || frame_err || busy || rx_byte !== 8'h00) bad++;
      end
      check("idle quiet", bad, 0);

      idle(5);
      send_frame(8'hA5, 1'b1, f);
      idle(10);
      expect_ev("a5", f + LAT, 1'b0, 8'hA5, t1);
      check("a5 busy rise", busy_rise_t, f + 3);
      check("a5 busy fall", busy_fall_t, f + LAT);
      check("a5 extra", evq.size(), 0);

      idle(5);
      f = cyc;
      rx = 1'b0;
      repeat (4) tick();
      idle(30);
      check("glitch pulses", evq.size(), 0);
      check("glitch busy rise", busy_rise_t, f + 3);
      check("glitch idle at", busy_fall_t, f + OS / 2 + 3);
      check("glitch busy", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) begin
         idle(5);
         send_frame(tbl[i].d, tbl[i].stop, f);
         if (!tbl[i].stop) begin
            rx = 1'b0;
            repeat (40) tick();
            check($sformatf("vec%0d busy held", i), 32'(busy), 32'd1);
            nr = n_busy_rise;
            idle(6);
            check($sformatf("vec%0d busy off", i), 32'(busy), 32'd0);
            idle(200);
            check($sformatf("vec%0d no restart", i), n_busy_rise, nr);
         end else begin
            idle(10);
         end
         expect_ev($sformatf("vec%0d", i), f + LAT, tbl[i].ferr,
                   tbl[i].eb, t1);
         check($sformatf("vec%0d rx_byte", i), 32'(rx_byte),
               32'(tbl[i].eb));
         check($sformatf("vec%0d extra", i), evq.size(), 0);
      end

      idle(5);
      send_frame(8'h00, 1'b1, f);
      send_frame(8'hFF, 1'b1, f2);
      idle(20);
      expect_ev("b2b first", f + LAT, 1'b0, 8'h00, t1);
      expect_ev("b2b second", f2 + LAT, 1'b0, 8'hFF, t2);
      check("b2b spacing", t2 - t1, 160);

      idle(5);
      d = 8'h5A;
      rx = 1'b0;
      repeat (OS) tick();
      for (int k = 0; k < 4; k++) hold(d[k]);
      rx = d[4];
      repeat (OS / 2) tick();
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) tick();
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst rx_byte", 32'(rx_byte), 32'h00);
      rst = 1'b0;
      idle(200);
      check("midrst no pulse", evq.size(), 0);
      send_frame(8'h81, 1'b1, f);
      idle(10);
      expect_ev("after rst", f + LAT, 1'b0, 8'h81, t1);
      check("after rst extra", evq.size(), 0);

      last_good = 8'h81;
      idle(5);
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, stop, f);
         expq.push_back('{f + LAT, !stop, stop ? d : last_good});
         if (stop) begin
            last_good = d;
            lo = $urandom_range(0, 25);
            if (lo > 0) idle(lo);
         end else begin
            lo = $urandom_range(0, 40);
            rx = 1'b0;
            repeat (lo) tick();
            idle($urandom_range(4, 25));
         end
      end
      idle(20);
      check("rand count", evq.size(), expq.size());
      while (evq.size() > 0 && expq.size() > 0) begin
         ev_t a, e;
         a = evq.pop_front();
         e = expq.pop_front();
         check("rand time", a.t, e.t);
         check("rand kind", 32'(a.ferr), 32'(e.ferr));
         check("rand byte", 32'(a.b), 32'(e.b));
      end

      check("valid+ferr overlap", n_both, 0);
      check("pulse width", n_long, 0);
      check("byte change w/o valid", n_bytechg, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
